// File: rtl/core_pkg.sv
// Shared core types: scheduler-to-register-read packet plus issue-queue dispatch and entry records.
package core_pkg;

  localparam int NUM_PREGS = 64;
  localparam int PREG_W    = $clog2(NUM_PREGS);

  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    logic [31:0] pc;
    preg_t       src1_preg;
    preg_t       src2_preg;
    preg_t       dst_preg;
    logic [31:0] imm_val;
    logic        instr_valid;
  } sched_pkt_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm_val;
    preg_t       src1_preg;
    preg_t       src2_preg;
    preg_t       dst_preg;
    logic        src1_rdy;
    logic        src2_rdy;
  } iq_disp_pkt_t;

  typedef struct packed {
    logic        v;
    logic        r1;
    logic        r2;
    logic [31:0] pc;
    logic [31:0] imm_val;
    preg_t       src1_preg;
    preg_t       src2_preg;
    preg_t       dst_preg;
  } iq_entry_t;

  function automatic logic preg_hit(input logic bc_valid, input preg_t bc_preg, input preg_t src);
    return bc_valid && (bc_preg == src);
  endfunction

  function automatic iq_entry_t wake_entry(input iq_entry_t e, input logic bc_valid, input preg_t bc_preg);
    iq_entry_t w;
    w    = e;
    w.r1 = e.r1 | preg_hit(bc_valid, bc_preg, e.src1_preg);
    w.r2 = e.r2 | preg_hit(bc_valid, bc_preg, e.src2_preg);
    return w;
  endfunction

  function automatic sched_pkt_t entry_to_pkt(input iq_entry_t e);
    sched_pkt_t p;
    p.pc          = e.pc;
    p.src1_preg   = e.src1_preg;
    p.src2_preg   = e.src2_preg;
    p.dst_preg    = e.dst_preg;
    p.imm_val     = e.imm_val;
    p.instr_valid = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/scheduler_reg_read_if.sv
// Scheduler-to-register-read handoff: one registered fire strobe plus its packet.
interface scheduler_reg_read_if;

  logic                fire_valid;
  core_pkg::sched_pkt_t sched_pkt;

  modport sched (output fire_valid, output sched_pkt);
  modport rr    (input  fire_valid, input  sched_pkt);

endinterface

// File: rtl/iq_select.sv
// Combinational lowest-index priority picker over a request vector.
module iq_select #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  output logic                 pick_valid,
  output logic [$clog2(N)-1:0] pick_idx
);

  localparam int IDX_W = $clog2(N);

  // Scan from the top down so the lowest requesting index wins last.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pick_idx   = req[i] ? IDX_W'(i) : pick_idx;
      pick_valid = pick_valid | req[i];
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Collapsing out-of-order issue queue; oldest ready entry fires to register read each cycle.
// Optional IQ_BACK_TO_BACK_WAKEUP_EN: the picked entry's dst_preg also wakes dependents at the same edge.
module issue_queue import core_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  iq_disp_pkt_t             disp_pkt,
  input  logic                     wb_valid,
  input  logic [PREG_W-1:0]        wb_preg,
  scheduler_reg_read_if.sched      sched_if,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  iq_entry_t         entries_r     [DEPTH];
  iq_entry_t         entries_ext_s [DEPTH+1];
  iq_entry_t         entries_nxt_s [DEPTH];
  iq_entry_t         new_entry_s;
  iq_entry_t         picked_s;
  logic [OCC_W-1:0]  occupancy_r;
  logic [OCC_W-1:0]  occ_nxt_s;
  logic [OCC_W-1:0]  wr_idx_s;
  logic [DEPTH-1:0]  req_s;
  logic              pick_valid_s;
  logic [IDX_W-1:0]  pick_idx_s;
  logic              accept_s;
  logic              b2b_valid_s;
  preg_t             b2b_preg_s;
  logic              fire_valid_r;
  sched_pkt_t        sched_pkt_r;

  // Ready-to-issue request vector.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      req_s[i] = entries_r[i].v & entries_r[i].r1 & entries_r[i].r2;
    end
  end

  iq_select #(.N(DEPTH)) u_select (
    .req        (req_s),
    .pick_valid (pick_valid_s),
    .pick_idx   (pick_idx_s)
  );

  assign picked_s   = entries_r[pick_idx_s];
  assign disp_ready = (occupancy_r < OCC_W'(DEPTH)) && !flush;
  assign accept_s   = disp_valid && disp_ready;
  // The slot above the last survivor after the collapse.
  assign wr_idx_s   = occupancy_r - {{(OCC_W-1){1'b0}}, pick_valid_s};
  assign occ_nxt_s  = occupancy_r + {{(OCC_W-1){1'b0}}, accept_s}
                                  - {{(OCC_W-1){1'b0}}, pick_valid_s};

`ifdef IQ_BACK_TO_BACK_WAKEUP_EN
  assign b2b_valid_s = pick_valid_s && (picked_s.dst_preg != {PREG_W{1'b0}});
  assign b2b_preg_s  = picked_s.dst_preg;
`else
  assign b2b_valid_s = 1'b0;
  assign b2b_preg_s  = {PREG_W{1'b0}};
`endif

  // Incoming entry with readiness from flags, preg 0, and same-cycle broadcasts.
  always_comb begin
    new_entry_s.v         = 1'b1;
    new_entry_s.pc        = disp_pkt.pc;
    new_entry_s.imm_val   = disp_pkt.imm_val;
    new_entry_s.src1_preg = disp_pkt.src1_preg;
    new_entry_s.src2_preg = disp_pkt.src2_preg;
    new_entry_s.dst_preg  = disp_pkt.dst_preg;
    new_entry_s.r1        = disp_pkt.src1_rdy | (disp_pkt.src1_preg == {PREG_W{1'b0}})
                          | preg_hit(wb_valid, wb_preg, disp_pkt.src1_preg)
                          | preg_hit(b2b_valid_s, b2b_preg_s, disp_pkt.src1_preg);
    new_entry_s.r2        = disp_pkt.src2_rdy | (disp_pkt.src2_preg == {PREG_W{1'b0}})
                          | preg_hit(wb_valid, wb_preg, disp_pkt.src2_preg)
                          | preg_hit(b2b_valid_s, b2b_preg_s, disp_pkt.src2_preg);
  end

  // Collapse over the picked slot, apply wakeups, then append the dispatch.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_ext_s[i] = entries_r[i];
    end
    entries_ext_s[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entries_nxt_s[i] = (pick_valid_s && (i >= int'(pick_idx_s))) ? entries_ext_s[i+1]
                                                                   : entries_ext_s[i];
      entries_nxt_s[i] = wake_entry(entries_nxt_s[i], wb_valid, wb_preg);
      entries_nxt_s[i] = wake_entry(entries_nxt_s[i], b2b_valid_s, b2b_preg_s);
      entries_nxt_s[i] = (accept_s && (wr_idx_s == OCC_W'(i))) ? new_entry_s : entries_nxt_s[i];
    end
  end

  // Queue state, occupancy and registered fire output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
      occupancy_r  <= '0;
      fire_valid_r <= 1'b0;
      sched_pkt_r  <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
      occupancy_r  <= '0;
      fire_valid_r <= 1'b0;
      sched_pkt_r  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= entries_nxt_s[i];
      end
      occupancy_r  <= occ_nxt_s;
      fire_valid_r <= pick_valid_s;
      sched_pkt_r  <= pick_valid_s ? entry_to_pkt(picked_s) : '0;
    end
  end

  assign sched_if.fire_valid = fire_valid_r;
  assign sched_if.sched_pkt  = sched_pkt_r;
  assign occupancy           = occupancy_r;

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: fire packets go through a scoreboard, timing checked per scenario.
module tb_issue_queue;
  import core_pkg::*;

  localparam int DEPTH = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  flush = 1'b0;
  logic                  disp_valid = 1'b0;
  logic                  disp_ready;
  iq_disp_pkt_t          disp_pkt = '0;
  logic                  wb_valid = 1'b0;
  logic [PREG_W-1:0]     wb_preg = '0;
  logic [$clog2(DEPTH):0] occupancy;

  scheduler_reg_read_if sif ();

  issue_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .disp_valid (disp_valid),
    .disp_ready (disp_ready),
    .disp_pkt   (disp_pkt),
    .wb_valid   (wb_valid),
    .wb_preg    (wb_preg),
    .sched_if   (sif),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  sched_pkt_t exp_q [$];
  sched_pkt_t mon_exp;

  // Scoreboard: every fire must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && sif.fire_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_fire got pc=%h want no fire", sif.sched_pkt.pc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (sif.sched_pkt !== mon_exp) begin
          bad++;
          $display("FAIL fire_pkt got=%h want=%h", sif.sched_pkt, mon_exp);
        end
      end
    end
  end

  function automatic sched_pkt_t mk_exp(input logic [31:0] pc, input logic [PREG_W-1:0] s1,
                                        input logic [PREG_W-1:0] s2, input logic [PREG_W-1:0] dst,
                                        input logic [31:0] imm);
    sched_pkt_t p;
    p.pc = pc; p.src1_preg = s1; p.src2_preg = s2; p.dst_preg = dst;
    p.imm_val = imm; p.instr_valid = 1'b1;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_disp(input logic [31:0] pc, input logic [PREG_W-1:0] s1, input logic r1,
                            input logic [PREG_W-1:0] s2, input logic r2,
                            input logic [PREG_W-1:0] dst, input logic [31:0] imm);
    disp_valid = 1'b1;
    disp_pkt.pc = pc; disp_pkt.src1_preg = s1; disp_pkt.src1_rdy = r1;
    disp_pkt.src2_preg = s2; disp_pkt.src2_rdy = r2; disp_pkt.dst_preg = dst; disp_pkt.imm_val = imm;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (sif.fire_valid !== 1'b0) begin bad++; $display("FAIL rst_fire got=%b want=0", sif.fire_valid); end
    total++; if (sif.sched_pkt !== '0) begin bad++; $display("FAIL rst_pkt got=%h want=0", sif.sched_pkt); end
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL rst_occ got=%0d want=0", occupancy); end
    rst = 1'b1;
    tick();
    @(negedge clk);
    total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", disp_ready); end
  endtask

  task automatic test_basic();
    tick();
    drive_disp(32'h1000, 6'd5, 1'b1, 6'd10, 1'b1, 6'd15, 32'h42);
    exp_q.push_back(mk_exp(32'h1000, 6'd5, 6'd10, 6'd15, 32'h42));
    tick(); disp_valid = 1'b0;
    @(negedge clk);
    total++; if (occupancy !== 4'd1) begin bad++; $display("FAIL basic_occ1 got=%0d want=1", occupancy); end
    total++; if (sif.fire_valid !== 1'b0) begin bad++; $display("FAIL basic_early got=%b want=0", sif.fire_valid); end
    tick(); @(negedge clk);
    total++; if (sif.fire_valid !== 1'b1) begin bad++; $display("FAIL basic_fire got=%b want=1", sif.fire_valid); end
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL basic_occ0 got=%0d want=0", occupancy); end
    tick(); @(negedge clk);
    total++; if (sif.fire_valid !== 1'b0) begin bad++; $display("FAIL basic_empty got=%b want=0", sif.fire_valid); end
  endtask

  // Dispatch and issue in the same cycle; preg 0 and same-cycle writeback count as ready.
  task automatic test_steady();
    logic [3:0] want_occ [3];
    want_occ[0] = 4'd1; want_occ[1] = 4'd1; want_occ[2] = 4'd0;
    tick();
    drive_disp(32'h6000, 6'd60, 1'b1, 6'd61, 1'b1, 6'd1, 32'h0);
    exp_q.push_back(mk_exp(32'h6000, 6'd60, 6'd61, 6'd1, 32'h0));
    tick();
    drive_disp(32'h6004, 6'd0, 1'b0, 6'd0, 1'b0, 6'd2, 32'h4);
    exp_q.push_back(mk_exp(32'h6004, 6'd0, 6'd0, 6'd2, 32'h4));
    @(negedge clk);
    total++; if (occupancy !== 4'd1) begin bad++; $display("FAIL steady_occ_a got=%0d want=1", occupancy); end
    tick();
    drive_disp(32'h6008, 6'd25, 1'b0, 6'd62, 1'b1, 6'd3, 32'h8);
    wb_valid = 1'b1; wb_preg = 6'd25;
    exp_q.push_back(mk_exp(32'h6008, 6'd25, 6'd62, 6'd3, 32'h8));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (sif.fire_valid !== 1'b1) begin bad++; $display("FAIL steady_fire%0d got=%b want=1", k, sif.fire_valid); end
      total++; if (occupancy !== want_occ[k]) begin bad++; $display("FAIL steady_occ%0d got=%0d want=%0d", k, occupancy, want_occ[k]); end
      tick(); disp_valid = 1'b0; wb_valid = 1'b0;
    end
    @(negedge clk);
    total++; if (sif.fire_valid !== 1'b0) begin bad++; $display("FAIL steady_end got=%b want=0", sif.fire_valid); end
  endtask

  task automatic test_wakeup_order();
    tick();
    drive_disp(32'h2000, 6'd20, 1'b0, 6'd21, 1'b1, 6'd22, 32'h1);
    tick();
    drive_disp(32'h2004, 6'd23, 1'b1, 6'd24, 1'b1, 6'd25, 32'h2);
    exp_q.push_back(mk_exp(32'h2004, 6'd23, 6'd24, 6'd25, 32'h2));
    tick(); disp_valid = 1'b0;
    @(negedge clk);
    total++; if (sif.fire_valid !== 1'b0) begin bad++; $display("FAIL wk_a_notready got=%b want=0", sif.fire_valid); end
    total++; if (occupancy !== 4'd2) begin bad++; $display("FAIL wk_occ2 got=%0d want=2", occupancy); end
    tick(); @(negedge clk);
    total++; if (sif.fire_valid !== 1'b1) begin bad++; $display("FAIL wk_b_fire got=%b want=1", sif.fire_valid); end
    tick();
    wb_valid = 1'b1; wb_preg = 6'd20;
    exp_q.push_back(mk_exp(32'h2000, 6'd20, 6'd21, 6'd22, 32'h1));
    @(negedge clk);
    total++; if (occupancy !== 4'd1) begin bad++; $display("FAIL wk_occ1 got=%0d want=1", occupancy); end
    tick(); wb_valid = 1'b0;
    @(negedge clk);
    total++; if (sif.fire_valid !== 1'b0) begin bad++; $display("FAIL wk_a_early got=%b want=0", sif.fire_valid); end
    tick(); @(negedge clk);
    total++; if (sif.fire_valid !== 1'b1) begin bad++; $display("FAIL wk_a_fire got=%b want=1", sif.fire_valid); end
    tick();
  endtask

  task automatic test_full();
    logic [31:0] want_pc;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      drive_disp(32'h3000 + 32'(4 * i), 6'd30, 1'b0, 6'd0, 1'b0, 6'(31 + i), 32'(i));
      exp_q.push_back(mk_exp(32'h3000 + 32'(4 * i), 6'd30, 6'd0, 6'(31 + i), 32'(i)));
      @(negedge clk);
      total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL full_ready%0d got=%b want=1", i, disp_ready); end
    end
    tick();
    drive_disp(32'h3FFC, 6'd1, 1'b1, 6'd1, 1'b1, 6'd1, 32'h0);
    @(negedge clk);
    total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", disp_ready); end
    total++; if (occupancy !== 4'd8) begin bad++; $display("FAIL full_occ got=%0d want=8", occupancy); end
    tick(); disp_valid = 1'b0;
    wb_valid = 1'b1; wb_preg = 6'd30;
    @(negedge clk);
    total++; if (occupancy !== 4'd8) begin bad++; $display("FAIL full_reject got=%0d want=8", occupancy); end
    tick(); wb_valid = 1'b0;
    @(negedge clk);
    total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL full_issue_ready got=%b want=0", disp_ready); end
    for (int k = 0; k < DEPTH; k++) begin
      tick(); @(negedge clk);
      want_pc = 32'h3000 + 32'(4 * k);
      total++; if (sif.fire_valid !== 1'b1) begin bad++; $display("FAIL full_fire%0d got=%b want=1", k, sif.fire_valid); end
      total++; if (sif.sched_pkt.pc !== want_pc) begin bad++; $display("FAIL full_pc%0d got=%h want=%h", k, sif.sched_pkt.pc, want_pc); end
      total++; if (occupancy !== 4'(7 - k)) begin bad++; $display("FAIL full_occ%0d got=%0d want=%0d", k, occupancy, 7 - k); end
    end
    tick(); @(negedge clk);
    total++; if (sif.fire_valid !== 1'b0) begin bad++; $display("FAIL full_drain got=%b want=0", sif.fire_valid); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      tick();
      drive_disp(32'h4000 + 32'(4 * i), 6'd40, 1'b0, 6'd41, 1'b1, 6'd42, 32'h0);
    end
    tick(); disp_valid = 1'b0;
    wb_valid = 1'b1; wb_preg = 6'd40;
    @(negedge clk);
    total++; if (occupancy !== 4'd4) begin bad++; $display("FAIL fl_occ4 got=%0d want=4", occupancy); end
    tick(); wb_valid = 1'b0; flush = 1'b1;
    drive_disp(32'h40F0, 6'd1, 1'b1, 6'd1, 1'b1, 6'd1, 32'h0);
    @(negedge clk);
    total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL fl_ready got=%b want=0", disp_ready); end
    tick(); flush = 1'b0; disp_valid = 1'b0;
    @(negedge clk);
    total++; if (sif.fire_valid !== 1'b0) begin bad++; $display("FAIL fl_fire got=%b want=0", sif.fire_valid); end
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL fl_occ got=%0d want=0", occupancy); end
    tick(); wb_valid = 1'b1; wb_preg = 6'd40;
    tick(); wb_valid = 1'b0;
    tick(); tick();
    drive_disp(32'h4100, 6'd43, 1'b1, 6'd44, 1'b1, 6'd45, 32'h99);
    exp_q.push_back(mk_exp(32'h4100, 6'd43, 6'd44, 6'd45, 32'h99));
    tick(); disp_valid = 1'b0;
    tick(); @(negedge clk);
    total++; if (sif.fire_valid !== 1'b1) begin bad++; $display("FAIL fl_after got=%b want=1", sif.fire_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    tick();
    drive_disp(32'h5000, 6'd50, 1'b1, 6'd51, 1'b1, 6'd7, 32'h5);
    exp_q.push_back(mk_exp(32'h5000, 6'd50, 6'd51, 6'd7, 32'h5));
    tick();
    drive_disp(32'h5004, 6'd7, 1'b0, 6'd52, 1'b1, 6'd53, 32'h6);
`ifdef IQ_BACK_TO_BACK_WAKEUP_EN
    exp_q.push_back(mk_exp(32'h5004, 6'd7, 6'd52, 6'd53, 32'h6));
`endif
    tick(); disp_valid = 1'b0;
    @(negedge clk);
    total++; if (sif.fire_valid !== 1'b1) begin bad++; $display("FAIL b2b_a got=%b want=1", sif.fire_valid); end
    tick(); @(negedge clk);
`ifdef IQ_BACK_TO_BACK_WAKEUP_EN
    total++; if (sif.fire_valid !== 1'b1) begin bad++; $display("FAIL b2b_b got=%b want=1", sif.fire_valid); end
`else
    total++; if (sif.fire_valid !== 1'b0) begin bad++; $display("FAIL b2b_b_wait got=%b want=0", sif.fire_valid); end
    wb_valid = 1'b1; wb_preg = 6'd7;
    exp_q.push_back(mk_exp(32'h5004, 6'd7, 6'd52, 6'd53, 32'h6));
    tick(); wb_valid = 1'b0;
    tick(); @(negedge clk);
    total++; if (sif.fire_valid !== 1'b1) begin bad++; $display("FAIL b2b_b_wb got=%b want=1", sif.fire_valid); end
`endif
    tick(); @(negedge clk);
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL b2b_occ got=%0d want=0", occupancy); end
  endtask

  task automatic test_async_reset();
    tick();
    drive_disp(32'h7000, 6'd2, 1'b1, 6'd3, 1'b1, 6'd4, 32'h7);
    exp_q.push_back(mk_exp(32'h7000, 6'd2, 6'd3, 6'd4, 32'h7));
    tick();
    drive_disp(32'h7004, 6'd63, 1'b0, 6'd3, 1'b1, 6'd5, 32'h8);
    tick(); disp_valid = 1'b0;
    @(negedge clk);
    total++; if (occupancy !== 4'd1) begin bad++; $display("FAIL ar_occ1 got=%0d want=1", occupancy); end
    #1 rst = 1'b0;
    #1;
    total++; if (sif.fire_valid !== 1'b0) begin bad++; $display("FAIL ar_fire got=%b want=0", sif.fire_valid); end
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL ar_occ got=%0d want=0", occupancy); end
    tick(); rst = 1'b1;
    wb_valid = 1'b1; wb_preg = 6'd63;
    tick(); wb_valid = 1'b0;
    tick(); tick(); @(negedge clk);
    total++; if (sif.fire_valid !== 1'b0) begin bad++; $display("FAIL ar_cleared got=%b want=0", sif.fire_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_steady();
    test_wakeup_order();
    test_full();
    test_flush();
    test_back_to_back();
    test_async_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d outstanding want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
